// File: rtl/uart_hex_reporter.sv
// rtl/uart_hex_reporter.sv - UART transmit front-end merging a byte-echo FIFO with atomic hex value reports
module uart_hex_reporter #(
    parameter int WIDTH      = 32,
    parameter int ECHO_DEPTH = 4,
    parameter int PREFIX     = 1,
    parameter int NEWLINE    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value,
    input  logic             value_strobe,
    output logic             value_dropped,
    output logic             busy,
    input  logic [7:0]       echo_byte,
    input  logic             echo_strobe,
    output logic             echo_dropped,
    output logic [7:0]       txd,
    input  logic             txd_ready,
    output logic             txd_strobe
);
    localparam int DIGITS = WIDTH / 4;
    localparam int DW     = $clog2(DIGITS) + 1;
    localparam int AW     = $clog2(ECHO_DEPTH);
    localparam int CW     = AW + 1;

    typedef enum logic [2:0] {IDLE, ECHO, PFX0, PFX1, DIGIT, CR, LF, GAP} state_t;

    state_t           state, state_next, ret, ret_next, ret_cand;
    logic [7:0]       mem [ECHO_DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sreg;
    logic [DW-1:0]    dcount;

    logic       push_ok, full, accept;
    logic       emit, issue, pop, load_digits, last;
    logic [7:0] char, hex;
    logic [3:0] nib;

    assign full    = (count == CW'(ECHO_DEPTH));
    assign push_ok = echo_strobe && !full;
    assign accept  = value_strobe && !busy;
    assign nib     = sreg[WIDTH-1 -: 4];
    assign hex     = (nib < 4'd10) ? {4'h3, nib} : 8'h37 + {4'h0, nib};

    // IDLE looks at this cycle's push/strobe too, so the first byte goes out two cycles after the request.
    always_comb begin
        state_next  = state;
        ret_next    = ret;
        ret_cand    = IDLE;
        emit        = 1'b0;
        issue       = 1'b0;
        pop         = 1'b0;
        load_digits = 1'b0;
        last        = 1'b0;
        char        = 8'h00;
        case (state)
            IDLE: begin
                if (count != '0 || push_ok) begin
                    state_next = ECHO;
                end else if (busy || value_strobe) begin
                    state_next  = (PREFIX != 0) ? PFX0 : DIGIT;
                    load_digits = 1'b1;
                end
            end
            ECHO: begin
                emit = 1'b1;
                char = mem[rd_ptr];
                pop  = txd_ready;
            end
            PFX0: begin
                emit     = 1'b1;
                char     = 8'h30;
                ret_cand = PFX1;
            end
            PFX1: begin
                emit     = 1'b1;
                char     = 8'h78;
                ret_cand = DIGIT;
            end
            DIGIT: begin
                emit = 1'b1;
                char = hex;
                if (dcount == DW'(1)) begin
                    ret_cand = (NEWLINE != 0) ? CR : IDLE;
                    last     = (NEWLINE == 0);
                end else begin
                    ret_cand = DIGIT;
                end
            end
            CR: begin
                emit     = 1'b1;
                char     = 8'h0D;
                ret_cand = LF;
            end
            LF: begin
                emit = 1'b1;
                char = 8'h0A;
                last = 1'b1;
            end
            GAP:     state_next = ret;
            default: state_next = IDLE;
        endcase
        if (emit && txd_ready) begin
            issue      = 1'b1;
            state_next = GAP;
            ret_next   = ret_cand;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ret   <= IDLE;
        end else begin
            state <= state_next;
            ret   <= ret_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem[wr_ptr] <= echo_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            txd           <= 8'h00;
            txd_strobe    <= 1'b0;
            busy          <= 1'b0;
            value_dropped <= 1'b0;
            echo_dropped  <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            sreg          <= '0;
            dcount        <= '0;
        end else begin
            txd_strobe    <= issue;
            value_dropped <= value_strobe && busy;
            echo_dropped  <= echo_strobe && full;
            if (issue) begin
                txd <= char;
            end
            if (accept) begin
                sreg <= value;
                busy <= 1'b1;
            end else begin
                if (issue && state == DIGIT) begin
                    sreg <= sreg << 4;
                end
                if (issue && last) begin
                    busy <= 1'b0;
                end
            end
            if (load_digits) begin
                dcount <= DW'(DIGITS);
            end else if (issue && state == DIGIT) begin
                dcount <= dcount - DW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop);
        end
    end
endmodule
